// File: rtl/daq_pixel_pack.sv
// Purpose: packs capture-stage pixel bytes little-endian into 32-bit words, adds a frame header word, buffers them in a FWFT FIFO.
// Latency: a word completed at edge E (or a header/flush raised at E) is written at E+1 and shown on word_out in the next cycle.
// Backpressure: word_vld/word_rdy toward the SPI transmitter; a word that meets a full FIFO (no read that cycle) is dropped and counted.
//
// Ports: sys_clk/sys_rst_n (async active-low), data_in[7:0] + state[2:0] from the capture stage,
//        word_rdy in; word_out[31:0], word_vld, fifo_cnt[FIFO_AW:0], frame_cnt[15:0], ovf_cnt[15:0] out.
// Option: define PACK_LINE_TRAILER_EN to append {16'hC33C, 6'b0, line_bytes} after every line end.

module daq_pixel_pack #(
  parameter int          FIFO_AW   = 4,
  parameter logic [15:0] HDR_MAGIC = 16'hA55A
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [7:0]         data_in,
  input  logic [2:0]         state,
  input  logic               word_rdy,
  output logic [31:0]        word_out,
  output logic               word_vld,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        ovf_cnt
);

  // ROT needs no decode: anything other than FOT/WR_EN behaves as idle here.
  localparam logic [2:0] ST_FOT   = 3'b001;
  localparam logic [2:0] ST_WR_EN = 3'b010;

  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] fnum;
  } hdr_t;

  typedef enum logic [1:0] {P_IDLE, P_HDR, P_LINE, P_LEND} pstate_t;

  logic [2:0]  state_d1;
  logic        byte_vld;
  logic        byte_vld_d1;
  logic        frame_start;
  logic        line_end;
  logic [1:0]  idx;
  logic [1:0]  idx_nx;
  logic [31:0] pack;
  logic [31:0] pack_nx;
  logic [15:0] frame_cnt_nx;

  logic        wc_flag;
  logic        flush_flag;
  logic        hdr_flag;
  logic [31:0] wc_word;
  logic [31:0] flush_word;
  hdr_t        hdr_word;
  logic        wc_gnt;
  logic        flush_gnt;
  logic        hdr_gnt;
  logic        lend_busy;

  logic        wr_vld;
  logic        wr_rdy;
  logic [31:0] wr_dat;

  pstate_t     pstate;

`ifdef PACK_LINE_TRAILER_EN
  logic        trl_flag;
  logic        trl_gnt;
  logic [31:0] trl_word;
  logic [9:0]  line_bytes;
`endif

  // data_in lags the WR_EN sample by one edge, so bytes are qualified by the delayed state.
  assign byte_vld     = (state_d1 == ST_WR_EN);
  assign frame_start  = (state == ST_FOT) && (state_d1 != ST_FOT);
  assign line_end     = byte_vld_d1 && !byte_vld;
  assign frame_cnt_nx = frame_cnt + 16'd1;

`ifdef PACK_LINE_TRAILER_EN
  assign lend_busy = flush_flag | trl_flag;
`else
  assign lend_busy = flush_flag;
`endif

  // Lane insertion; starting a new word clears the upper lanes so a flushed partial word is zero-padded.
  always_comb begin
    pack_nx = pack;
    idx_nx  = idx;
    if (byte_vld) begin
      if (idx == 2'd0) begin
        pack_nx = {24'h0, data_in};
      end else begin
        pack_nx[{idx, 3'b000} +: 8] = data_in;
      end
      idx_nx = idx + 2'd1;
    end
  end

  // One FIFO write per cycle; losers keep their flag and retry next cycle.
  always_comb begin
    wc_gnt    = 1'b0;
    flush_gnt = 1'b0;
    hdr_gnt   = 1'b0;
`ifdef PACK_LINE_TRAILER_EN
    trl_gnt   = 1'b0;
`endif
    wr_vld    = 1'b1;
    wr_dat    = '0;
    if (wc_flag) begin
      wc_gnt = 1'b1;
      wr_dat = wc_word;
    end else if (flush_flag) begin
      flush_gnt = 1'b1;
      wr_dat    = flush_word;
`ifdef PACK_LINE_TRAILER_EN
    end else if (trl_flag) begin
      trl_gnt = 1'b1;
      wr_dat  = trl_word;
`endif
    end else if (hdr_flag) begin
      hdr_gnt = 1'b1;
      wr_dat  = hdr_word;
    end else begin
      wr_vld = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_d1    <= 3'b000;
      byte_vld_d1 <= 1'b0;
      idx         <= 2'd0;
      pack        <= '0;
      wc_flag     <= 1'b0;
      flush_flag  <= 1'b0;
      hdr_flag    <= 1'b0;
      wc_word     <= '0;
      flush_word  <= '0;
      hdr_word    <= '0;
      frame_cnt   <= '0;
      ovf_cnt     <= '0;
      pstate      <= P_IDLE;
`ifdef PACK_LINE_TRAILER_EN
      trl_flag    <= 1'b0;
      trl_word    <= '0;
      line_bytes  <= '0;
`endif
    end else begin
      state_d1    <= state;
      byte_vld_d1 <= byte_vld;
      pack        <= pack_nx;
      idx         <= idx_nx;

      if (byte_vld && (idx == 2'd3)) begin
        wc_flag <= 1'b1;
        wc_word <= pack_nx;
      end else if (wc_gnt) begin
        wc_flag <= 1'b0;
      end

      // A frame start mid-word is treated like a line end so the partial word survives.
      if ((frame_start || line_end) && (idx_nx != 2'd0)) begin
        flush_flag <= 1'b1;
        flush_word <= pack_nx;
      end else if (flush_gnt) begin
        flush_flag <= 1'b0;
      end
      if (frame_start || line_end) begin
        idx <= 2'd0;
      end

      if (frame_start) begin
        frame_cnt <= frame_cnt_nx;
        hdr_flag  <= 1'b1;
        hdr_word  <= {HDR_MAGIC, frame_cnt_nx};
      end else if (hdr_gnt) begin
        hdr_flag <= 1'b0;
      end

`ifdef PACK_LINE_TRAILER_EN
      // Trailer captures the count now; the counter restarts for the next line.
      if (line_end) begin
        trl_flag   <= 1'b1;
        trl_word   <= {16'hC33C, 6'b0, line_bytes};
        line_bytes <= '0;
      end else begin
        if (trl_gnt) begin
          trl_flag <= 1'b0;
        end
        if (byte_vld && (line_bytes != 10'h3FF)) begin
          line_bytes <= line_bytes + 10'd1;
        end
      end
`endif

      if (wr_vld && !wr_rdy && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end

      if (frame_start) begin
        pstate <= P_HDR;
      end else begin
        case (pstate)
          P_HDR:   if (hdr_gnt)    pstate <= P_LINE;
          P_LINE:  if (line_end)   pstate <= P_LEND;
          P_LEND:  if (!lend_busy) pstate <= P_LINE;
          default: ;
        endcase
      end
    end
  end

  daq_pp_fifo #(
    .DW (32),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .wr_vld (wr_vld),
    .wr_dat (wr_dat),
    .wr_rdy (wr_rdy),
    .rd_vld (word_vld),
    .rd_dat (word_out),
    .rd_rdy (word_rdy),
    .cnt    (fifo_cnt)
  );

endmodule

// Purpose: generic first-word-fall-through FIFO, head word visible whenever rd_vld is high.
// Latency: a write at edge N is readable in the cycle after N.
// Backpressure: wr_rdy drops when full unless a read frees a slot in the same cycle.
module daq_pp_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  output logic          wr_rdy,
  output logic          rd_vld,
  output logic [DW-1:0] rd_dat,
  input  logic          rd_rdy,
  output logic [AW:0]   cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign rd_vld = (cnt != '0);
  assign do_rd  = rd_vld && rd_rdy;
  assign wr_rdy = !cnt[AW] || do_rd;
  assign do_wr  = wr_vld && wr_rdy;
  // Gate the head so stale or unwritten storage never shows while empty.
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_daq_pixel_pack.sv
`timescale 1ns/1ps
module tb_daq_pixel_pack;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_FOT  = 3'b001;
  localparam logic [2:0] S_WR   = 3'b010;
  localparam logic [2:0] S_ROT  = 3'b100;
`ifdef PACK_LINE_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [7:0]  data_in   = 8'h00;
  logic [2:0]  state     = 3'b000;
  logic        word_rdy  = 1'b1;
  logic [31:0] word_out;
  logic        word_vld;
  logic [4:0]  fifo_cnt;
  logic [15:0] frame_cnt;
  logic [15:0] ovf_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  logic [7:0]  lb[$];
  bit          rand_rdy = 1'b0;

  typedef struct {
    int          n;
    logic [7:0]  b0;
    int          ne;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t tbl[5];

  always #5 sys_clk = ~sys_clk;

  daq_pixel_pack dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data_in   (data_in),
    .state     (state),
    .word_rdy  (word_rdy),
    .word_out  (word_out),
    .word_vld  (word_vld),
    .fifo_cnt  (fifo_cnt),
    .frame_cnt (frame_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read monitor plus head-stability check while the transmitter stalls.
  logic        hold_prev = 1'b0;
  logic [31:0] hold_word = '0;
  always @(negedge sys_clk) begin
    if (sys_rst_n && word_vld && word_rdy) got.push_back(word_out);
    if (hold_prev && sys_rst_n) begin
      checks++;
      if (!(word_vld === 1'b1 && word_out === hold_word)) begin
        errors++;
        $display("FAIL hold: got vld=%b word=%h expected vld=1 word=%h", word_vld, word_out, hold_word);
      end
    end
    hold_prev = sys_rst_n && word_vld && !word_rdy;
    hold_word = word_out;
  end

  task automatic step(input logic [2:0] st, input logic [7:0] d);
    state   = st;
    data_in = d;
    if (rand_rdy) word_rdy = ($urandom_range(0, 3) != 0);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [2:0] st);
    repeat (n) step(st, 8'h00);
  endtask

  // WR_EN for lb.size() cycles; each byte arrives on data_in one cycle after its WR_EN sample.
  task automatic run_line(input logic [2:0] post);
    step(S_WR, 8'h00);
    for (int i = 0; i < lb.size() - 1; i++) step(S_WR, lb[i]);
    step(post, lb[lb.size() - 1]);
  endtask

  // Reference: little-endian groups of four, zero-padded remainder, optional trailer.
  function automatic void model_line();
    logic [31:0] w;
    int k;
    w = '0;
    k = 0;
    foreach (lb[i]) begin
      w[8*k +: 8] = lb[i];
      k++;
      if (k == 4) begin
        exp_q.push_back(w);
        w = '0;
        k = 0;
      end
    end
    if (k != 0) exp_q.push_back(w);
    if (TRL != 0) exp_q.push_back({16'hC33C, 6'b0, 10'(lb.size())});
  endfunction

  task automatic cmp_q(input string name);
    logic [31:0] a;
    chk($sformatf("%s count", name), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      a = 'x;
      if (i < got.size()) a = got[i];
      chk($sformatf("%s word%0d", name, i), a, exp_q[i]);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic fill_lb(input int n, input logic [7:0] b0);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(b0 + 8'(i));
  endtask

  initial begin
    int fc;
    tbl[0] = '{8, 8'h01, 2, 32'h04030201, 32'h08070605};
    tbl[1] = '{6, 8'h11, 2, 32'h14131211, 32'h00001615};
    tbl[2] = '{1, 8'hA0, 1, 32'h000000A0, 32'h0};
    tbl[3] = '{4, 8'hF0, 1, 32'hF3F2F1F0, 32'h0};
    tbl[4] = '{3, 8'h30, 1, 32'h00323130, 32'h0};

    #1 sys_rst_n = 1'b0;
    #3;
    chk("rst word_out", word_out, 32'h0);
    chk("rst word_vld", word_vld, 0);
    chk("rst fifo_cnt", fifo_cnt, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst ovf_cnt", ovf_cnt, 0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Header latency and value.
    step(S_FOT, 8'h00);
    chk("hdr lat F", word_vld, 0);
    step(S_FOT, 8'h00);
    chk("hdr lat F+1 vld", word_vld, 1);
    chk("hdr lat F+1 word", word_out, 32'hA55A0001);
    idle(5, S_IDLE);
    exp_q.push_back(32'hA55A0001);
    cmp_q("hdr1");
    chk("frame_cnt 1", frame_cnt, 1);

    // Table of lines inside frame 1.
    for (int t = 0; t < 5; t++) begin
      fill_lb(tbl[t].n, tbl[t].b0);
      run_line(S_ROT);
      idle(6, S_IDLE);
      exp_q.push_back(tbl[t].e0);
      if (tbl[t].ne > 1) exp_q.push_back(tbl[t].e1);
      if (TRL != 0) exp_q.push_back({16'hC33C, 6'b0, 10'(tbl[t].n)});
      cmp_q($sformatf("tbl%0d", t));
    end

    // Fourth byte at edge E: not visible after E, visible after E+1.
    fill_lb(4, 8'hC0);
    run_line(S_ROT);
    chk("wc lat E", word_vld, 0);
    step(S_ROT, 8'h00);
    chk("wc lat E+1 vld", word_vld, 1);
    chk("wc lat E+1 word", word_out, 32'hC3C2C1C0);
    idle(5, S_IDLE);
    exp_q.push_back(32'hC3C2C1C0);
    if (TRL != 0) exp_q.push_back(32'hC33C0004);
    cmp_q("wc lat");

    // Flush latency: byte_vld low seen at L, flush written at L+1.
    word_rdy = 1'b0;
    fill_lb(5, 8'hD0);
    run_line(S_ROT);
    chk("flush pre", fifo_cnt, 1);
    step(S_ROT, 8'h00);
    chk("flush L", fifo_cnt, 1);
    step(S_ROT, 8'h00);
    chk("flush L+1", fifo_cnt, 2);
    word_rdy = 1'b1;
    idle(8, S_IDLE);
    exp_q.push_back(32'hD3D2D1D0);
    exp_q.push_back(32'h000000D4);
    if (TRL != 0) exp_q.push_back(32'hC33C0005);
    cmp_q("flush");

    // Frame start mid-word keeps the partial word, then the header follows.
    fill_lb(6, 8'h11);
    run_line(S_FOT);
    step(S_FOT, 8'h00);
    idle(6, S_IDLE);
    exp_q.push_back(32'h14131211);
    exp_q.push_back(32'h00001615);
    if (TRL != 0) exp_q.push_back(32'hC33C0006);
    exp_q.push_back(32'hA55A0002);
    cmp_q("midfot");
    chk("frame_cnt 2", frame_cnt, 2);

    // Overflow: header + 20 words into depth 16.
    word_rdy = 1'b0;
    step(S_FOT, 8'h00);
    step(S_FOT, 8'h00);
    fill_lb(80, 8'h00);
    run_line(S_ROT);
    idle(6, S_IDLE);
    chk("ovf fifo_cnt", fifo_cnt, 16);
    chk("ovf ovf_cnt", ovf_cnt, 5 + TRL);
    chk("ovf head", word_out, 32'hA55A0003);
    word_rdy = 1'b1;
    idle(20, S_IDLE);
    exp_q.push_back(32'hA55A0003);
    for (int k = 0; k < 15; k++)
      exp_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    cmp_q("ovf drain");
    chk("ovf empty", fifo_cnt, 0);

    // Full FIFO, read and write in the same cycle.
    word_rdy = 1'b0;
    fill_lb(64, 8'h80);
    run_line(S_ROT);
    idle(4, S_IDLE);
    model_line();
    if (TRL != 0) void'(exp_q.pop_back());
    chk("full fifo_cnt", fifo_cnt, 16);
    fill_lb(4, 8'hE0);
    run_line(S_ROT);
    word_rdy = 1'b1;
    step(S_ROT, 8'h00);
    word_rdy = 1'b0;
    chk("rw fifo_cnt", fifo_cnt, 16);
    chk("rw ovf_cnt", ovf_cnt, 5 + 2*TRL);
    idle(4, S_IDLE);
    chk("rw ovf after", ovf_cnt, 5 + 3*TRL);
    word_rdy = 1'b1;
    idle(20, S_IDLE);
    exp_q.push_back(32'hE3E2E1E0);
    cmp_q("rw drain");

    // Reset in the middle of a line.
    step(S_FOT, 8'h00);
    idle(3, S_IDLE);
    step(S_WR, 8'h00);
    step(S_WR, 8'h51);
    step(S_WR, 8'h52);
    step(S_WR, 8'h53);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mrst word_out", word_out, 32'h0);
    chk("mrst word_vld", word_vld, 0);
    chk("mrst fifo_cnt", fifo_cnt, 0);
    chk("mrst frame_cnt", frame_cnt, 0);
    chk("mrst ovf_cnt", ovf_cnt, 0);
    state = S_IDLE;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    got.delete();
    step(S_FOT, 8'h00);
    step(S_FOT, 8'h00);
    idle(5, S_IDLE);
    exp_q.push_back(32'hA55A0001);
    cmp_q("post rst hdr");
    chk("post rst frame_cnt", frame_cnt, 1);

    // Randomized frames/lines with a random transmitter against the reference model.
    fc = 1;
    rand_rdy = 1'b1;
    for (int f = 0; f < 4; f++) begin
      fc++;
      repeat ($urandom_range(1, 3)) step(S_FOT, 8'h00);
      exp_q.push_back({16'hA55A, 16'(fc)});
      idle($urandom_range(0, 2), S_IDLE);
      repeat ($urandom_range(1, 4)) begin
        logic [2:0] post;
        int n;
        n = $urandom_range(1, 20);
        lb.delete();
        for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
        case ($urandom_range(0, 2))
          0:       post = S_ROT;
          1:       post = S_IDLE;
          default: post = 3'b111;
        endcase
        run_line(post);
        model_line();
        idle($urandom_range(1, 3), post);
      end
    end
    rand_rdy = 1'b0;
    word_rdy = 1'b1;
    idle(60, S_IDLE);
    cmp_q("rand");
    chk("rand ovf_cnt", ovf_cnt, 0);
    chk("rand frame_cnt", frame_cnt, 32'(fc));
    chk("rand empty", word_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
